sr_ff: RTL and testbench
========================

Name: sr_ff

Overview:
Clocked set/reset flip-flop bank with complementary outputs. Each bit samples its S/R pair on the rising clock edge and sets, clears or holds its stored state. The behaviour when S and R are both asserted is fixed by a parameter. Used as a generic control/flag storage element wherever a set-dominant, clear-dominant or hold-type flag register is needed.

Parameters:
WIDTH, 1, number of independent SR flip-flops; all ports except clk/rst are WIDTH bits.
BOTH_MODE, 0, action when S=1 and R=1 on a bit: 0 = hold, 1 = set, 2 = clear, 3 = toggle.
INIT, 0 (all bits), power-up value of Q before any reset or clock edge; also the value loaded by rst.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  synchronous reset, active-high; Q loads INIT at the rising edge while rst=1.
S  input  WIDTH  per-bit set request.
R  input  WIDTH  per-bit reset (clear) request.
Q  output  WIDTH  stored state, driven directly from the register.
Q_bar  output  WIDTH  bitwise complement of Q at all times.

Behaviour:
- Interface: one clock (clk). rst is synchronous and active-high. There is no asynchronous path.
- Storage: one WIDTH-bit register q. Q = q; Q_bar = ~q combinationally. Q and Q_bar must never be equal on any bit.
- Power-up: q is initialised to INIT, so Q/Q_bar are defined (Q=0, Q_bar=1 by default) before the first edge. This matters when rst is left unconnected or tied low.
- Reset: at a rising edge with rst=1, q <= INIT regardless of S/R. Reset has priority over every S/R combination. rst asserted mid-operation takes effect on the next edge only.
- Per-bit update at a rising edge with rst=0:
  - S=0, R=0: hold.
  - S=1, R=0: q <= 1.
  - S=0, R=1: q <= 0.
  - S=1, R=1: resolved per BOTH_MODE (hold / 1 / 0 / ~q).
- Bits are fully independent. No cross-bit interaction.
- Latency: one clock. Q reflects the S/R sampled at edge n immediately after edge n. There is no combinational path from S/R to Q.
- Between edges, S/R changes have no effect (edge-triggered, not a latch).
- rst is treated as 0 if it is not 1. An undriven or X rst must not force reset; the implementation uses the "if (rst)" form.
- Illegal BOTH_MODE values (>3) behave as 0 (hold).

Test Plan:
- Defaults (WIDTH=1, BOTH_MODE=0), clk period 10 with first rising edge at 5. Stimulus changes at 10,20,...: S/R = 00,10,00,01,00,11,10. Required Q after edges 5/15/25/35/45/55/65 = 0/1/1/0/0/0/1. Q_bar is always the complement.
- Reset priority: with Q=1, drive S=1,R=0,rst=1 for one edge -> Q=0, Q_bar=1. Deassert rst -> Q=1 on the next edge.
- Synchronous reset: pulse rst high between edges and drop it before the next edge -> Q unchanged.
- BOTH_MODE sweep with S=R=1 for three edges, starting from Q=0: mode1 -> 1,1,1; mode2 -> 0,0,0; mode3 -> 1,0,1; mode0 -> 0,0,0.
- WIDTH=4, S=4'b0101, R=4'b0011 from Q=4'b1000 -> Q=4'b1100 with BOTH_MODE=0 (bit0 hold). Q_bar=4'b0011.
- S/R glitch pulses that start and end between edges -> no change on Q.

Source files
------------

// File: rtl/sr_ff.sv
// Clocked SR flip-flop bank with complementary outputs.
// The S=R=1 case is resolved at elaboration time by BOTH_MODE.
module sr_ff #(
  parameter int              WIDTH     = 1,
  parameter int              BOTH_MODE = 0,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar
);

  // Out-of-range modes fall back to hold.
  localparam int MODE = (BOTH_MODE >= 0 && BOTH_MODE <= 3) ? BOTH_MODE : 0;

  // Declaration initialiser gives a defined power-up value even when rst is tied low.
  logic [WIDTH-1:0] q_reg = INIT;
  logic [WIDTH-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_next;

      always_comb begin
        bit_next = q_reg[gi];
        case ({S[gi], R[gi]})
          2'b10: bit_next = 1'b1;
          2'b01: bit_next = 1'b0;
          2'b11: begin
            case (MODE)
              1:       bit_next = 1'b1;
              2:       bit_next = 1'b0;
              3:       bit_next = ~q_reg[gi];
              default: bit_next = q_reg[gi];
            endcase
          end
          default: bit_next = q_reg[gi];
        endcase
      end

      assign q_next[gi] = bit_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= INIT;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q     = q_reg;
  assign Q_bar = ~q_reg;

endmodule

// File: tb/tb_sr_ff.sv
// Directed self-checking bench for sr_ff: default sequence, reset behaviour,
// S=R=1 mode sweep, illegal mode, non-zero INIT and a 4-bit bank.
module tb_sr_ff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance: WIDTH=1, BOTH_MODE=0, INIT=0
  logic rst0 = 1'b0, s0 = 1'b0, r0 = 1'b0;
  logic q0, qb0;
  sr_ff u0 (.clk(clk), .rst(rst0), .S(s0), .R(r0), .Q(q0), .Q_bar(qb0));

  // mode sweep instances share their stimulus
  logic rstm = 1'b0, sm = 1'b0, rm = 1'b0;
  logic q1, qb1, q2, qb2, q3, qb3, q5, qb5;
  sr_ff #(.BOTH_MODE(1)) u1 (.clk(clk), .rst(rstm), .S(sm), .R(rm), .Q(q1), .Q_bar(qb1));
  sr_ff #(.BOTH_MODE(2)) u2 (.clk(clk), .rst(rstm), .S(sm), .R(rm), .Q(q2), .Q_bar(qb2));
  sr_ff #(.BOTH_MODE(3)) u3 (.clk(clk), .rst(rstm), .S(sm), .R(rm), .Q(q3), .Q_bar(qb3));
  sr_ff #(.BOTH_MODE(5)) u5 (.clk(clk), .rst(rstm), .S(sm), .R(rm), .Q(q5), .Q_bar(qb5));

  // non-zero INIT instance
  logic rst6 = 1'b0, s6 = 1'b0, r6 = 1'b0;
  logic q6, qb6;
  sr_ff #(.INIT(1'b1)) u6 (.clk(clk), .rst(rst6), .S(s6), .R(r6), .Q(q6), .Q_bar(qb6));

  // 4-bit bank
  logic       rst4 = 1'b0;
  logic [3:0] s4 = 4'b0000, r4 = 4'b0000;
  logic [3:0] q4, qb4;
  sr_ff #(.WIDTH(4)) u4 (.clk(clk), .rst(rst4), .S(s4), .R(r4), .Q(q4), .Q_bar(qb4));

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic q, input logic qb, input logic exp);
    check({tag, ".Q"},     {3'b000, q},  {3'b000, exp});
    check({tag, ".Q_bar"}, {3'b000, qb}, {3'b000, ~exp});
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_sr  [7] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10};
  logic       seq_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       m1_exp  [3] = '{1'b1, 1'b1, 1'b1};
  logic       m3_exp  [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    #1;
    check1("powerup_u0", q0, qb0, 1'b0);
    check1("powerup_init1", q6, qb6, 1'b1);

    // basic sequence, values sampled at edges 5..65
    for (int i = 0; i < 7; i++) begin
      {s0, r0} = seq_sr[i];
      edge_wait();
      check1($sformatf("seq%0d", i), q0, qb0, seq_exp[i]);
      $display("seq step %0d: S/R=%b Q=%b Q_bar=%b", i, seq_sr[i], q0, qb0);
    end

    // reset beats a simultaneous set
    s0 = 1'b1; r0 = 1'b0; rst0 = 1'b1;
    edge_wait();
    check1("rst_priority", q0, qb0, 1'b0);
    rst0 = 1'b0;
    edge_wait();
    check1("rst_release", q0, qb0, 1'b1);

    // rst pulse wholly between edges
    s0 = 1'b0;
    @(negedge clk); rst0 = 1'b1; #2; rst0 = 1'b0;
    edge_wait();
    check1("rst_between_edges", q0, qb0, 1'b1);

    // S/R glitches between edges
    @(negedge clk); r0 = 1'b1; #2; r0 = 1'b0;
    edge_wait();
    check1("r_glitch", q0, qb0, 1'b1);
    r0 = 1'b1;
    edge_wait();
    check1("clear", q0, qb0, 1'b0);
    r0 = 1'b0;
    @(negedge clk); s0 = 1'b1; #2; s0 = 1'b0;
    edge_wait();
    check1("s_glitch", q0, qb0, 1'b0);

    // BOTH_MODE sweep from Q=0; u0 is the mode-0 case
    rstm = 1'b1;
    edge_wait();
    check1("m3_reset", q3, qb3, 1'b0);
    rstm = 1'b0; sm = 1'b1; rm = 1'b1; s0 = 1'b1; r0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check1($sformatf("mode1_%0d", i), q1, qb1, m1_exp[i]);
      check1($sformatf("mode2_%0d", i), q2, qb2, 1'b0);
      check1($sformatf("mode3_%0d", i), q3, qb3, m3_exp[i]);
      check1($sformatf("mode0_%0d", i), q0, qb0, 1'b0);
      check1($sformatf("mode5_%0d", i), q5, qb5, 1'b0);
      $display("sweep edge %0d: m0=%b m1=%b m2=%b m3=%b m5=%b", i, q0, q1, q2, q3, q5);
    end
    sm = 1'b0; rm = 1'b0; s0 = 1'b0; r0 = 1'b0;

    // reset loads a non-zero INIT
    r6 = 1'b1;
    edge_wait();
    check1("init1_clear", q6, qb6, 1'b0);
    rst6 = 1'b1;
    edge_wait();
    check1("init1_reset", q6, qb6, 1'b1);
    rst6 = 1'b0; r6 = 1'b0;

    // 4-bit bank
    check("w4_powerup.Q", q4, 4'b0000);
    s4 = 4'b1000;
    edge_wait();
    check("w4_load.Q", q4, 4'b1000);
    s4 = 4'b0101; r4 = 4'b0011;
    edge_wait();
    check("w4_mix.Q", q4, 4'b1100);
    check("w4_mix.Q_bar", qb4, 4'b0011);
    $display("w4 S=0101 R=0011: Q=%b Q_bar=%b", q4, qb4);
    s4 = 4'b1111; r4 = 4'b0000;
    edge_wait();
    check("w4_setall.Q", q4, 4'b1111);
    s4 = 4'b0010; r4 = 4'b1101;
    edge_wait();
    check("w4_partial.Q", q4, 4'b0010);
    check("w4_partial.Q_bar", qb4, 4'b1101);
    s4 = 4'b1111; r4 = 4'b0000; rst4 = 1'b1;
    edge_wait();
    check("w4_reset.Q", q4, 4'b0000);
    check("w4_reset.Q_bar", qb4, 4'b1111);
    rst4 = 1'b0; s4 = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
